// File: rtl/ob_pkg.sv
// Shared constants and FSM state type for the order book engine.
package ob_pkg;

    localparam logic SIDE_BUY  = 1'b0;
    localparam logic SIDE_SELL = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/ob_side.sv
// One side of the book: a price-sorted shift array of resting unit orders.
// Slots at index >= count are always zero, so the head reads 0 when the side is empty.
module ob_side #(
    parameter int PRICE_W    = 8,
    parameter int DEPTH      = 8,
    parameter bit DESCENDING = 1'b1,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               insert,
    input  logic               pop,
    input  logic [PRICE_W-1:0] ins_price,
    output logic [PRICE_W-1:0] head,
    output logic               valid,
    output logic [CNT_W-1:0]   count,
    output logic               full
);

    logic [DEPTH-1:0][PRICE_W-1:0] arr_q;
    logic [DEPTH-1:0][PRICE_W-1:0] arr_d;
    logic [CNT_W-1:0]              count_q;
    logic [CNT_W-1:0]              count_d;
    logic [DEPTH-1:0]              ahead;
    logic                          do_pop;
    logic                          do_ins;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign do_pop = pop && (count_q != '0);
    assign do_ins = insert && !full;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PRICE_W-1:0] prev_w;
            logic [PRICE_W-1:0] next_w;
            logic               prev_ahead;

            // Equal prices stay ahead of the newcomer, giving time priority.
            if (DESCENDING) begin : g_desc
                assign ahead[gi] = (CNT_W'(gi) < count_q) && (arr_q[gi] >= ins_price);
            end else begin : g_asc
                assign ahead[gi] = (CNT_W'(gi) < count_q) && (arr_q[gi] <= ins_price);
            end

            if (gi == 0) begin : g_first
                assign prev_w     = '0;
                assign prev_ahead = 1'b1;
            end else begin : g_rest
                assign prev_w     = arr_q[gi-1];
                assign prev_ahead = ahead[gi-1];
            end

            if (gi == DEPTH - 1) begin : g_last
                assign next_w = '0;
            end else begin : g_inner
                assign next_w = arr_q[gi+1];
            end

            assign arr_d[gi] = clear      ? '0 :
                               do_pop     ? next_w :
                               !do_ins    ? arr_q[gi] :
                               ahead[gi]  ? arr_q[gi] :
                               prev_ahead ? ins_price : prev_w;
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (do_pop) begin
            count_d = count_q - CNT_W'(1);
        end else if (do_ins) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arr_q   <= '0;
            count_q <= '0;
        end else begin
            arr_q   <= arr_d;
            count_q <= count_d;
        end
    end

    assign head  = arr_q[0];
    assign valid = (count_q != '0);
    assign count = count_q;

endmodule

// File: rtl/order_book_engine.sv
// Unit-order matching engine: accepts one order per handshake, then either hits
// the best opposite level or rests it in price-time order on its own side.
module order_book_engine
    import ob_pkg::*;
#(
    parameter int PRICE_W = 8,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_side,
    input  logic [PRICE_W-1:0] in_price,
    input  logic               halt,
    input  logic               flush,
    output logic               trade_valid,
    output logic [PRICE_W-1:0] trade_price,
    output logic               trade_side,
    output logic               reject,
    output logic [PRICE_W-1:0] best_bid,
    output logic [PRICE_W-1:0] best_ask,
    output logic               bid_valid,
    output logic               ask_valid,
    output logic [CNT_W-1:0]   bid_count,
    output logic [CNT_W-1:0]   ask_count,
    output logic [PRICE_W-1:0] spread
);

    state_t             state_q, state_d;
    logic               side_q, side_d;
    logic [PRICE_W-1:0] price_q, price_d;
    logic               trade_valid_q, trade_valid_d;
    logic [PRICE_W-1:0] trade_price_q, trade_price_d;
    logic               trade_side_q, trade_side_d;
    logic               reject_q, reject_d;

    logic               bid_clear, bid_insert, bid_pop, bid_full;
    logic               ask_clear, ask_insert, ask_pop, ask_full;
    logic [PRICE_W-1:0] bid_head, ask_head;
    logic               bid_nonempty, ask_nonempty;
    logic               cross_buy, cross_sell;

    ob_side #(
        .PRICE_W   (PRICE_W),
        .DEPTH     (DEPTH),
        .DESCENDING(1'b1),
        .CNT_W     (CNT_W)
    ) u_bids (
        .clk      (clk),
        .reset    (reset),
        .clear    (bid_clear),
        .insert   (bid_insert),
        .pop      (bid_pop),
        .ins_price(price_q),
        .head     (bid_head),
        .valid    (bid_nonempty),
        .count    (bid_count),
        .full     (bid_full)
    );

    ob_side #(
        .PRICE_W   (PRICE_W),
        .DEPTH     (DEPTH),
        .DESCENDING(1'b0),
        .CNT_W     (CNT_W)
    ) u_asks (
        .clk      (clk),
        .reset    (reset),
        .clear    (ask_clear),
        .insert   (ask_insert),
        .pop      (ask_pop),
        .ins_price(price_q),
        .head     (ask_head),
        .valid    (ask_nonempty),
        .count    (ask_count),
        .full     (ask_full)
    );

    assign cross_buy  = (side_q == SIDE_BUY)  && ask_nonempty && (price_q >= ask_head);
    assign cross_sell = (side_q == SIDE_SELL) && bid_nonempty && (price_q <= bid_head);

    always_comb begin
        state_d       = state_q;
        side_d        = side_q;
        price_d       = price_q;
        trade_valid_d = 1'b0;
        trade_price_d = '0;
        trade_side_d  = 1'b0;
        reject_d      = 1'b0;
        bid_clear     = 1'b0;
        bid_insert    = 1'b0;
        bid_pop       = 1'b0;
        ask_clear     = 1'b0;
        ask_insert    = 1'b0;
        ask_pop       = 1'b0;
        in_ready      = (state_q == IDLE) && !halt && !flush && !reset;

        // Flush outranks an order in flight; the pending order vanishes silently.
        if (flush) begin
            bid_clear = 1'b1;
            ask_clear = 1'b1;
            state_d   = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        side_d  = in_side;
                        price_d = in_price;
                        state_d = EXEC;
                    end
                end
                EXEC: begin
                    state_d = IDLE;
                    if (cross_buy) begin
                        ask_pop       = 1'b1;
                        trade_valid_d = 1'b1;
                        trade_price_d = ask_head;
                        trade_side_d  = SIDE_BUY;
                    end else if (cross_sell) begin
                        bid_pop       = 1'b1;
                        trade_valid_d = 1'b1;
                        trade_price_d = bid_head;
                        trade_side_d  = SIDE_SELL;
                    end else if (side_q == SIDE_BUY) begin
                        if (bid_full) reject_d   = 1'b1;
                        else          bid_insert = 1'b1;
                    end else begin
                        if (ask_full) reject_d   = 1'b1;
                        else          ask_insert = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            side_q        <= 1'b0;
            price_q       <= '0;
            trade_valid_q <= 1'b0;
            trade_price_q <= '0;
            trade_side_q  <= 1'b0;
            reject_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            side_q        <= side_d;
            price_q       <= price_d;
            trade_valid_q <= trade_valid_d;
            trade_price_q <= trade_price_d;
            trade_side_q  <= trade_side_d;
            reject_q      <= reject_d;
        end
    end

    assign trade_valid = trade_valid_q;
    assign trade_price = trade_price_q;
    assign trade_side  = trade_side_q;
    assign reject      = reject_q;
    assign best_bid    = bid_head;
    assign best_ask    = ask_head;
    assign bid_valid   = bid_nonempty;
    assign ask_valid   = ask_nonempty;
    // The book can never lock or cross, so this difference is never negative.
    assign spread      = (bid_nonempty && ask_nonempty) ? (ask_head - bid_head) : '0;

endmodule

// File: tb/tb_order_book_engine.sv
// Self-checking bench for order_book_engine: directed table, corner-case sequences
// and random orders checked against a queue-based book model.
module tb_order_book_engine;

    localparam int PRICE_W = 8;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic               in_side;
    logic [PRICE_W-1:0] in_price;
    logic               halt;
    logic               flush;
    logic               trade_valid;
    logic [PRICE_W-1:0] trade_price;
    logic               trade_side;
    logic               reject;
    logic [PRICE_W-1:0] best_bid;
    logic [PRICE_W-1:0] best_ask;
    logic               bid_valid;
    logic               ask_valid;
    logic [CNT_W-1:0]   bid_count;
    logic [CNT_W-1:0]   ask_count;
    logic [PRICE_W-1:0] spread;

    order_book_engine #(.PRICE_W(PRICE_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_side    (in_side),
        .in_price   (in_price),
        .halt       (halt),
        .flush      (flush),
        .trade_valid(trade_valid),
        .trade_price(trade_price),
        .trade_side (trade_side),
        .reject     (reject),
        .best_bid   (best_bid),
        .best_ask   (best_ask),
        .bid_valid  (bid_valid),
        .ask_valid  (ask_valid),
        .bid_count  (bid_count),
        .ask_count  (ask_count),
        .spread     (spread)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference book: bids best-first descending, asks best-first ascending.
    int bids[$];
    int asks[$];
    bit exp_tv, exp_ts, exp_rej;
    int exp_tp;
    bit cap_tv, cap_ts;
    int cap_tp;

    typedef struct {
        bit side;
        int price;
        bit tv;
        int tp;
        int bid;
        int ask;
        int bc;
        int ac;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic void model_apply(input bit s, input int p);
        int i;
        exp_tv  = 1'b0;
        exp_rej = 1'b0;
        exp_tp  = 0;
        exp_ts  = s;
        i       = 0;
        if (s == 1'b0) begin
            if (asks.size() > 0 && p >= asks[0]) begin
                exp_tv = 1'b1;
                exp_tp = asks.pop_front();
            end else if (bids.size() == DEPTH) begin
                exp_rej = 1'b1;
            end else begin
                while (i < bids.size() && bids[i] >= p) i++;
                bids.insert(i, p);
            end
        end else begin
            if (bids.size() > 0 && p <= bids[0]) begin
                exp_tv = 1'b1;
                exp_tp = bids.pop_front();
            end else if (asks.size() == DEPTH) begin
                exp_rej = 1'b1;
            end else begin
                while (i < asks.size() && asks[i] <= p) i++;
                asks.insert(i, p);
            end
        end
    endfunction

    task automatic check_book(input string tag);
        int eb, ea, es;
        eb = (bids.size() > 0) ? bids[0] : 0;
        ea = (asks.size() > 0) ? asks[0] : 0;
        es = (bids.size() > 0 && asks.size() > 0) ? ea - eb : 0;
        chk({tag, "_best_bid"}, 32'(best_bid), eb);
        chk({tag, "_best_ask"}, 32'(best_ask), ea);
        chk({tag, "_bid_count"}, 32'(bid_count), bids.size());
        chk({tag, "_ask_count"}, 32'(ask_count), asks.size());
        chk({tag, "_bid_valid"}, 32'(bid_valid), 32'(bids.size() > 0));
        chk({tag, "_ask_valid"}, 32'(ask_valid), 32'(asks.size() > 0));
        chk({tag, "_spread"}, 32'(spread), es);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_trade_valid"}, 32'(trade_valid), 0);
        chk({tag, "_trade_price"}, 32'(trade_price), 0);
        chk({tag, "_trade_side"}, 32'(trade_side), 0);
        chk({tag, "_reject"}, 32'(reject), 0);
        chk({tag, "_best_bid"}, 32'(best_bid), 0);
        chk({tag, "_best_ask"}, 32'(best_ask), 0);
        chk({tag, "_bid_valid"}, 32'(bid_valid), 0);
        chk({tag, "_ask_valid"}, 32'(ask_valid), 0);
        chk({tag, "_bid_count"}, 32'(bid_count), 0);
        chk({tag, "_ask_count"}, 32'(ask_count), 0);
        chk({tag, "_spread"}, 32'(spread), 0);
    endtask

    // Called at a negedge; returns at a negedge with the book settled and pulses gone.
    task automatic do_order(input bit s, input int p);
        int n;
        n        = 0;
        in_side  = s;
        in_price = PRICE_W'(p);
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        model_apply(s, p);
        @(posedge clk);
        @(negedge clk);
        cap_tv = trade_valid;
        cap_tp = 32'(trade_price);
        cap_ts = trade_side;
        chk("ord_trade_valid", 32'(trade_valid), 32'(exp_tv));
        chk("ord_reject", 32'(reject), 32'(exp_rej));
        if (exp_tv) begin
            chk("ord_trade_price", 32'(trade_price), exp_tp);
            chk("ord_trade_side", 32'(trade_side), 32'(exp_ts));
        end
        check_book("ord");
        $display("order side=%0d price=%0d trade=%0d tprice=%0d reject=%0d bid=%0d/%0d ask=%0d/%0d",
                 s, p, trade_valid, trade_price, reject, best_bid, bid_count, best_ask, ask_count);
        @(negedge clk);
        chk("pulse_tv_clear", 32'(trade_valid), 0);
        chk("pulse_rej_clear", 32'(reject), 0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        reset = 1'b0;
        bids.delete();
        asks.delete();
        @(negedge clk);
        chk("reset_release_ready", 32'(in_ready), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_side  = 1'b0;
        in_price = '0;
        halt     = 1'b0;
        flush    = 1'b0;

        //            side price tv tp  bid ask bc ac
        tbl[0]  = '{1'b0, 50, 1'b0,  0, 50,  0, 1, 0};
        tbl[1]  = '{1'b0, 52, 1'b0,  0, 52,  0, 2, 0};
        tbl[2]  = '{1'b0, 51, 1'b0,  0, 52,  0, 3, 0};
        tbl[3]  = '{1'b1, 55, 1'b0,  0, 52, 55, 3, 1};
        tbl[4]  = '{1'b1, 51, 1'b1, 52, 51, 55, 2, 1};
        tbl[5]  = '{1'b0, 55, 1'b1, 55, 51,  0, 2, 0};
        tbl[6]  = '{1'b1, 60, 1'b0,  0, 51, 60, 2, 1};
        tbl[7]  = '{1'b1, 62, 1'b0,  0, 51, 60, 2, 2};
        tbl[8]  = '{1'b1, 60, 1'b0,  0, 51, 60, 2, 3};
        tbl[9]  = '{1'b0, 70, 1'b1, 60, 51, 60, 2, 2};
        tbl[10] = '{1'b0, 59, 1'b0,  0, 59, 60, 3, 2};
        tbl[11] = '{1'b0, 60, 1'b1, 60, 59, 62, 3, 1};

        do_reset();

        for (int i = 0; i < 12; i++) begin
            do_order(tbl[i].side, tbl[i].price);
            chk("tbl_trade_valid", 32'(cap_tv), 32'(tbl[i].tv));
            if (tbl[i].tv) begin
                chk("tbl_trade_price", cap_tp, tbl[i].tp);
                chk("tbl_trade_side", 32'(cap_ts), 32'(tbl[i].side));
            end
            chk("tbl_best_bid", 32'(best_bid), tbl[i].bid);
            chk("tbl_best_ask", 32'(best_ask), tbl[i].ask);
            chk("tbl_bid_count", 32'(bid_count), tbl[i].bc);
            chk("tbl_ask_count", 32'(ask_count), tbl[i].ac);
            chk("tbl_spread", 32'(spread),
                (tbl[i].bc > 0 && tbl[i].ac > 0) ? tbl[i].ask - tbl[i].bid : 0);
        end

        // Halt holds off a waiting order without touching the book.
        halt     = 1'b1;
        in_side  = 1'b1;
        in_price = PRICE_W'(70);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("halt_in_ready", 32'(in_ready), 0);
            chk("halt_trade_valid", 32'(trade_valid), 0);
            chk("halt_ask_count", 32'(ask_count), asks.size());
        end
        halt = 1'b0;
        do_order(1'b1, 70);
        chk("halt_release_rest", 32'(ask_count), 2);

        // Flush during EXEC of a crossing sell: no trade, book empty.
        in_side  = 1'b1;
        in_price = PRICE_W'(40);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bids.delete();
        asks.delete();
        chk("flush_trade_valid", 32'(trade_valid), 0);
        chk("flush_reject", 32'(reject), 0);
        chk("flush_in_ready", 32'(in_ready), 0);
        check_book("flush");
        flush = 1'b0;
        @(negedge clk);
        chk("flush_release_ready", 32'(in_ready), 1);

        // Reset in the middle of a crossing order.
        do_order(1'b0, 30);
        do_order(1'b1, 35);
        in_side  = 1'b0;
        in_price = PRICE_W'(40);
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_zero("midreset");
        reset = 1'b0;
        bids.delete();
        asks.delete();
        @(negedge clk);

        // Fill bids to DEPTH, then a resting buy is rejected; a crossing sell still trades.
        for (int i = 0; i < DEPTH; i++) do_order(1'b0, 20 + i);
        chk("full_bid_count", 32'(bid_count), DEPTH);
        do_order(1'b0, 10);
        chk("full_reject_seen", 32'(exp_rej), 1);
        chk("full_bid_count_held", 32'(bid_count), DEPTH);
        do_order(1'b1, 5);
        chk("full_cross_trade_price", cap_tp, 27);

        // Random traffic against the reference book.
        do_reset();
        for (int i = 0; i < 200; i++) begin
            bit s;
            int p;
            s = 1'($urandom_range(0, 1));
            p = s ? int'($urandom_range(45, 75)) : int'($urandom_range(25, 55));
            do_order(s, p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/order_book_engine.md
# order_book_engine

Parametrised successor to the single-level matching engine: keeps a sorted book of up to DEPTH resting unit orders per side and accepts one order at a time over a valid/ready handshake. Each order either matches the best opposite level or rests in price-time order. Outputs are the trade pulse, best bid/ask, spread and level counts. It sits between order_generator and the counter/spread/display/VGA consumers in top.

## Interface
Parameters:
- PRICE_W, 8, price width in bits (unsigned)
- DEPTH, 8, maximum resting orders per side (≥2)
- CNT_W, $clog2(DEPTH+1), width of the count outputs

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high; one clock, sampled on rising edge of clk
- in_valid  in  1  order offered
- in_ready  out  1  engine can accept this cycle
- in_side  in  1  0 = buy, 1 = sell
- in_price  in  PRICE_W  limit price
- halt  in  1  blocks acceptance (in_ready forced 0); book is held
- flush  in  1  empties both sides
- trade_valid  out  1  one-cycle trade pulse
- trade_price  out  PRICE_W  price of the resting order that was hit
- trade_side  out  1  aggressor side
- reject  out  1  one-cycle pulse: order dropped, side full
- best_bid / best_ask  out  PRICE_W  top of each side; 0 when that side is empty
- bid_valid / ask_valid  out  1  side non-empty
- bid_count / ask_count  out  CNT_W  resting orders per side
- spread  out  PRICE_W  best_ask − best_bid when both sides are valid, else 0

## Operation
- FSM states: IDLE, EXEC.
- IDLE: in_ready = !halt && !flush && !reset. A handshake (in_valid && in_ready) latches side/price and moves to EXEC. A held in_valid does not start a second order until in_ready rises again.
- EXEC: one cycle, then always back to IDLE.
  - Buy crosses iff ask_valid && price ≥ best_ask. It removes the head of the ask array (shift up one) and pulses trade_valid with trade_price = best_ask and trade_side = 0.
  - Sell crosses iff bid_valid && price ≤ best_bid. It removes the bid head and pulses trade_valid with trade_price = best_bid and trade_side = 1.
  - A non-crossing order inserts sorted: bids descending, asks ascending. On equal price the new order goes behind the existing ones (time priority).
  - A non-crossing order into a full side (count == DEPTH) pulses reject and leaves the book unchanged.
  - Each order produces at most one trade; any remaining aggressor quantity is not retained.
- flush: takes priority over EXEC. A pending order is discarded with no trade or reject pulse. Counts go to 0 and the FSM returns to IDLE.
- A book that is locked or crossed cannot form; spread is never negative.

## Timing
- Handshake at edge N; EXEC occupies cycle N+1. The edge ending N+1 registers trade_valid/reject, the book, the bests, the counts and spread together; all are visible in cycle N+2.
- in_ready is high again in N+2 (if halt=0). Peak throughput is one order per 2 cycles.
- trade_valid and reject are high for exactly one cycle and are never asserted together.
- halt asserted during EXEC does not abort the order in flight.
- Reset values: every output 0 (including in_ready while reset is high); state IDLE; arrays cleared. A reset during EXEC loses the pending order with no pulse.
- Count arithmetic is in CNT_W bits. Counts saturate by construction: no insert at DEPTH, no removal at 0.

## Structure
- Package ob_pkg holds:
  - SIDE_BUY/SIDE_SELL constants
  - the state enum (IDLE, EXEC)
- Sub-module ob_side (parameters PRICE_W, DEPTH, DESCENDING):
  - holds one sorted register array plus count
  - ops: insert, pop_head, clear
  - outputs head, valid, count, full
- Instantiated twice: bids with DESCENDING=1, asks with DESCENDING=0.
- The top-level engine holds the FSM, cross compare, pulse registers and spread subtractor.

## Test plan
- Reset release, then buys 50, 52, 51 → bid_count = 3, best_bid = 52, ask_valid = 0, spread = 0, no trade_valid.
- With bids {52,51,50}, sell 55 then sell 51 → after the first, best_ask = 55 and spread = 3. The second pulses trade_valid with trade_price = 52, trade_side = 1; best_bid then = 51 and bid_count = 2.
- Asks {60,60(second),62}, buy 70 → trade at 60 and ask_count = 2 with the second 60 still at the head. A further buy 59 rests; best_bid = 59, spread = 1.
- Fill bids to DEPTH = 8, then a non-crossing buy 10 → reject pulses one cycle and bid_count stays 8. A crossing sell still trades normally.
- halt = 1 with in_valid held → in_ready = 0 and the book is unchanged. Releasing halt accepts the order; its result appears two cycles later.
- flush asserted during EXEC of a crossing order → both counts 0, best_bid = best_ask = 0, no trade_valid. Reset mid-stream → all outputs 0 the next cycle.
